// File: rtl/watch_pkg.sv
// ============================================================================
// Module : watch_pkg
// Brief  : Shared mode/cursor encodings for the watch mode controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package watch_pkg;

    typedef enum logic [1:0] {
        MODE_CLOCK     = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_ALARM = 2'd2
    } mode_e;

    localparam logic [1:0] DIG_H1 = 2'd0;
    localparam logic [1:0] DIG_H0 = 2'd1;
    localparam logic [1:0] DIG_M1 = 2'd2;
    localparam logic [1:0] DIG_M0 = 2'd3;

    // One bundle of strobes toward a setter block.
    typedef struct packed {
        logic start;
        logic next;
        logic up;
    } setter_pulse_t;

    function automatic logic is_set_mode(input mode_e m);
        return (m == MODE_SET_TIME) || (m == MODE_SET_ALARM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/edge_pulse.sv
// ============================================================================
// Module : edge_pulse
// Brief  : Rising-edge detector; history resets high so a held level is no edge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module edge_pulse (
    input  logic clk,
    input  logic reset,
    input  logic level_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level_i;
        end
    end

    assign rise_o = level_i & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/watch_mode_ctrl.sv
// ============================================================================
// Module : watch_mode_ctrl
// Brief  : Button-driven CLOCK/SET_TIME/SET_ALARM sequencer with cursor, blink
//          and idle-timeout handling; every output is registered.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module watch_mode_ctrl
    import watch_pkg::*;
#(
    parameter int BLINK_DIV = 25,
    parameter int TIMEOUT   = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_up,
    output logic [1:0] mode,
    output logic       st_start,
    output logic       st_next,
    output logic       st_up,
    output logic       al_start,
    output logic       al_next,
    output logic       al_up,
    output logic [1:0] cursor,
    output logic       blink,
    output logic       tk_hold,
    output logic       commit_time,
    output logic       commit_alarm
);

    localparam int BW = $clog2(BLINK_DIV);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [TW-1:0] IDLE_LAST  = TW'(TIMEOUT - 1);

    logic mode_rise;
    logic next_rise;
    logic up_rise;

    edge_pulse u_edge_mode (
        .clk     (clk),
        .reset   (reset),
        .level_i (btn_mode),
        .rise_o  (mode_rise)
    );

    edge_pulse u_edge_next (
        .clk     (clk),
        .reset   (reset),
        .level_i (btn_next),
        .rise_o  (next_rise)
    );

    edge_pulse u_edge_up (
        .clk     (clk),
        .reset   (reset),
        .level_i (btn_up),
        .rise_o  (up_rise)
    );

    mode_e         mode_q,         mode_d;
    logic [1:0]    cursor_q,       cursor_d;
    logic          blink_q,        blink_d;
    logic [BW-1:0] blink_cnt_q,    blink_cnt_d;
    logic [TW-1:0] idle_cnt_q,     idle_cnt_d;
    logic          tk_hold_q,      tk_hold_d;
    setter_pulse_t st_q,           st_d;
    setter_pulse_t al_q,           al_d;
    logic          commit_time_q,  commit_time_d;
    logic          commit_alarm_q, commit_alarm_d;

    logic in_time;
    assign in_time = (mode_q == MODE_SET_TIME);

    always_comb begin
        mode_d         = mode_q;
        cursor_d       = cursor_q;
        blink_d        = blink_q;
        blink_cnt_d    = blink_cnt_q;
        idle_cnt_d     = idle_cnt_q;
        st_d           = '0;
        al_d           = '0;
        commit_time_d  = 1'b0;
        commit_alarm_d = 1'b0;

        if (!is_set_mode(mode_q)) begin
            mode_d      = MODE_CLOCK;
            cursor_d    = DIG_H1;
            blink_d     = 1'b0;
            blink_cnt_d = '0;
            idle_cnt_d  = '0;
            if (mode_rise) begin
                mode_d   = MODE_SET_TIME;
                st_d.start = 1'b1;
                blink_d  = 1'b1;
            end
        end else if (mode_rise) begin
            // Leaving a set mode by the mode button never commits.
            cursor_d    = DIG_H1;
            blink_cnt_d = '0;
            idle_cnt_d  = '0;
            if (in_time) begin
                mode_d     = MODE_SET_ALARM;
                al_d.start = 1'b1;
                blink_d    = 1'b1;
            end else begin
                mode_d  = MODE_CLOCK;
                blink_d = 1'b0;
            end
        end else if (next_rise) begin
            blink_cnt_d = '0;
            idle_cnt_d  = '0;
            blink_d     = 1'b1;
            if (cursor_q != DIG_M0) begin
                cursor_d = cursor_q + 2'd1;
                if (in_time) begin
                    st_d.next = 1'b1;
                end else begin
                    al_d.next = 1'b1;
                end
            end else begin
                if (in_time) begin
                    commit_time_d = 1'b1;
                end else begin
                    commit_alarm_d = 1'b1;
                end
                mode_d   = MODE_CLOCK;
                cursor_d = DIG_H1;
                blink_d  = 1'b0;
            end
        end else if (up_rise) begin
            blink_cnt_d = '0;
            idle_cnt_d  = '0;
            blink_d     = 1'b1;
            if (in_time) begin
                st_d.up = 1'b1;
            end else begin
                al_d.up = 1'b1;
            end
        end else if (idle_cnt_q == IDLE_LAST) begin
            mode_d      = MODE_CLOCK;
            cursor_d    = DIG_H1;
            blink_d     = 1'b0;
            blink_cnt_d = '0;
            idle_cnt_d  = '0;
        end else begin
            idle_cnt_d = idle_cnt_q + TW'(1);
            if (blink_cnt_q == BLINK_LAST) begin
                blink_d     = ~blink_q;
                blink_cnt_d = '0;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end

        tk_hold_d = (mode_d == MODE_SET_TIME);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q         <= MODE_CLOCK;
            cursor_q       <= DIG_H1;
            blink_q        <= 1'b0;
            blink_cnt_q    <= '0;
            idle_cnt_q     <= '0;
            tk_hold_q      <= 1'b0;
            st_q           <= '0;
            al_q           <= '0;
            commit_time_q  <= 1'b0;
            commit_alarm_q <= 1'b0;
        end else begin
            mode_q         <= mode_d;
            cursor_q       <= cursor_d;
            blink_q        <= blink_d;
            blink_cnt_q    <= blink_cnt_d;
            idle_cnt_q     <= idle_cnt_d;
            tk_hold_q      <= tk_hold_d;
            st_q           <= st_d;
            al_q           <= al_d;
            commit_time_q  <= commit_time_d;
            commit_alarm_q <= commit_alarm_d;
        end
    end

    assign mode         = mode_q;
    assign cursor       = cursor_q;
    assign blink        = blink_q;
    assign tk_hold      = tk_hold_q;
    assign st_start     = st_q.start;
    assign st_next      = st_q.next;
    assign st_up        = st_q.up;
    assign al_start     = al_q.start;
    assign al_next      = al_q.next;
    assign al_up        = al_q.up;
    assign commit_time  = commit_time_q;
    assign commit_alarm = commit_alarm_q;

endmodule

`default_nettype wire

// File: tb/tb_watch_mode_ctrl.sv
// ============================================================================
// Module : tb_watch_mode_ctrl
// Brief  : Self-checking bench: vector table, corner sequences, random traffic.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_watch_mode_ctrl;

    localparam int BD = 4;
    localparam int TO = 20;

    logic       clk;
    logic       rst_n;
    logic       btn_mode, btn_next, btn_up;
    logic [1:0] mode, cursor;
    logic       st_start, st_next, st_up, al_start, al_next, al_up;
    logic       blink, tk_hold, commit_time, commit_alarm;

    watch_mode_ctrl #(.BLINK_DIV(BD), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .btn_mode     (btn_mode),
        .btn_next     (btn_next),
        .btn_up       (btn_up),
        .mode         (mode),
        .st_start     (st_start),
        .st_next      (st_next),
        .st_up        (st_up),
        .al_start     (al_start),
        .al_next      (al_next),
        .al_up        (al_up),
        .cursor       (cursor),
        .blink        (blink),
        .tk_hold      (tk_hold),
        .commit_time  (commit_time),
        .commit_alarm (commit_alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference: mode/cursor plus ages since the last blink restart and last button event.
    int m_mode, m_cursor, m_age, m_idle;
    bit pm, pn, pu;
    logic [7:0] m_pulses;

    function automatic void model_reset();
        m_mode = 0; m_cursor = 0; m_age = 0; m_idle = 0;
        pm = 1'b1; pn = 1'b1; pu = 1'b1;
        m_pulses = 8'h00;
    endfunction

    function automatic void model_step(input bit bm, input bit bn, input bit bu);
        bit em, en, eu;
        em = bm & !pm; en = bn & !pn; eu = bu & !pu;
        pm = bm; pn = bn; pu = bu;
        m_pulses = 8'h00;
        if (m_mode == 0) begin
            if (em) begin
                m_mode = 1; m_cursor = 0; m_age = 0; m_idle = 0; m_pulses = 8'h80;
            end
        end else if (em) begin
            if (m_mode == 1) begin
                m_mode = 2; m_pulses = 8'h10;
            end else begin
                m_mode = 0;
            end
            m_cursor = 0; m_age = 0; m_idle = 0;
        end else if (en) begin
            m_age = 0; m_idle = 0;
            if (m_cursor < 3) begin
                m_cursor++;
                m_pulses = (m_mode == 1) ? 8'h40 : 8'h08;
            end else begin
                m_pulses = (m_mode == 1) ? 8'h02 : 8'h01;
                m_mode = 0; m_cursor = 0;
            end
        end else if (eu) begin
            m_age = 0; m_idle = 0;
            m_pulses = (m_mode == 1) ? 8'h20 : 8'h04;
        end else begin
            m_age++; m_idle++;
            if (m_idle >= TO) begin
                m_mode = 0; m_cursor = 0;
            end
        end
    endfunction

    function automatic logic [13:0] model_vec();
        logic b;
        b = (m_mode != 0) && (((m_age / BD) % 2) == 0);
        return {2'(m_mode), 2'(m_cursor), b, (m_mode == 1), m_pulses};
    endfunction

    function automatic logic [13:0] dut_vec();
        return {mode, cursor, blink, tk_hold, st_start, st_next, st_up,
                al_start, al_next, al_up, commit_time, commit_alarm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit bm, input bit bn, input bit bu);
        @(negedge clk);
        btn_mode = bm; btn_next = bn; btn_up = bu;
        @(posedge clk);
        cyc++;
        model_step(bm, bn, bu);
        #1;
        check("model", 32'(dut_vec()), 32'(model_vec()));
    endtask

    typedef struct {
        logic [2:0] btn;
        logic [1:0] mode;
        logic [1:0] cursor;
        logic       blink;
        logic       tk;
        logic [7:0] pulses;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [2:0] b, input logic [1:0] m, input logic [1:0] c,
                       input logic bl, input logic tk, input logic [7:0] p);
        vec_t v;
        v.btn = b; v.mode = m; v.cursor = c; v.blink = bl; v.tk = tk; v.pulses = p;
        tbl.push_back(v);
    endtask

    function automatic bit rnd(input int pct);
        return $urandom_range(0, 99) < pct;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        bit found;

        // btn: {mode,next,up}; pulses: {st_start,st_next,st_up,al_start,al_next,al_up,ct,ca}
        add(3'b001, 0, 0, 0, 0, 8'h00); add(3'b000, 0, 0, 0, 0, 8'h00);
        add(3'b100, 1, 0, 1, 1, 8'h80); add(3'b000, 1, 0, 1, 1, 8'h00);
        add(3'b001, 1, 0, 1, 1, 8'h20); add(3'b000, 1, 0, 1, 1, 8'h00);
        add(3'b001, 1, 0, 1, 1, 8'h20); add(3'b000, 1, 0, 1, 1, 8'h00);
        add(3'b001, 1, 0, 1, 1, 8'h20); add(3'b000, 1, 0, 1, 1, 8'h00);
        add(3'b000, 1, 0, 1, 1, 8'h00); add(3'b000, 1, 0, 1, 1, 8'h00);
        add(3'b000, 1, 0, 0, 1, 8'h00); add(3'b010, 1, 1, 1, 1, 8'h40);
        add(3'b000, 1, 1, 1, 1, 8'h00); add(3'b010, 1, 2, 1, 1, 8'h40);
        add(3'b000, 1, 2, 1, 1, 8'h00); add(3'b010, 1, 3, 1, 1, 8'h40);
        add(3'b000, 1, 3, 1, 1, 8'h00); add(3'b010, 0, 0, 0, 0, 8'h02);
        add(3'b000, 0, 0, 0, 0, 8'h00); add(3'b100, 1, 0, 1, 1, 8'h80);
        add(3'b000, 1, 0, 1, 1, 8'h00); add(3'b100, 2, 0, 1, 0, 8'h10);
        add(3'b000, 2, 0, 1, 0, 8'h00); add(3'b010, 2, 1, 1, 0, 8'h08);
        add(3'b000, 2, 1, 1, 0, 8'h00); add(3'b011, 2, 2, 1, 0, 8'h08);
        add(3'b000, 2, 2, 1, 0, 8'h00); add(3'b010, 2, 3, 1, 0, 8'h08);
        add(3'b000, 2, 3, 1, 0, 8'h00); add(3'b010, 0, 0, 0, 0, 8'h01);
        add(3'b100, 1, 0, 1, 1, 8'h80); add(3'b000, 1, 0, 1, 1, 8'h00);
        add(3'b110, 2, 0, 1, 0, 8'h10); add(3'b000, 2, 0, 1, 0, 8'h00);
        add(3'b001, 2, 0, 1, 0, 8'h04); add(3'b000, 2, 0, 1, 0, 8'h00);
        add(3'b100, 0, 0, 0, 0, 8'h00); add(3'b010, 0, 0, 0, 0, 8'h00);
        add(3'b001, 0, 0, 0, 0, 8'h00); add(3'b000, 0, 0, 0, 0, 8'h00);
        add(3'b100, 1, 0, 1, 1, 8'h80); add(3'b100, 1, 0, 1, 1, 8'h00);
        add(3'b000, 1, 0, 1, 1, 8'h00); add(3'b100, 2, 0, 1, 0, 8'h10);
        add(3'b000, 2, 0, 1, 0, 8'h00); add(3'b100, 0, 0, 0, 0, 8'h00);
        add(3'b000, 0, 0, 0, 0, 8'h00);

        // Reset with btn_up held high.
        rst_n = 1'b0; btn_mode = 1'b0; btn_next = 1'b0; btn_up = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 32'(dut_vec()), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].btn[2], tbl[i].btn[1], tbl[i].btn[0]);
            check($sformatf("tbl%0d", i), 32'(dut_vec()),
                  32'({tbl[i].mode, tbl[i].cursor, tbl[i].blink, tbl[i].tk, tbl[i].pulses}));
        end

        // Idle timeout: back to CLOCK exactly TO cycles after entry.
        step(1, 0, 0);
        k = 0; found = 0;
        for (int j = 1; j <= 100 && !found; j++) begin
            step(0, 0, 0);
            if (mode == 2'd0) begin found = 1; k = j; end
        end
        check("timeout_idle", k, TO);

        // A next press at cycle 10 restarts the idle count.
        step(1, 0, 0);
        k = 0; found = 0;
        for (int j = 1; j <= 100 && !found; j++) begin
            step(0, (j == 10), 0);
            if (mode == 2'd0) begin found = 1; k = j; end
        end
        check("timeout_after_next", k, TO + 10);

        // Edge on the final idle cycle wins over the timeout.
        step(1, 0, 0);
        for (int j = 1; j < TO; j++) step(0, 0, 0);
        step(0, 0, 1);
        check("edge_beats_timeout", 32'({mode, st_up}), 32'({2'd1, 1'b1}));
        step(0, 0, 0); step(1, 0, 0); step(0, 0, 0); step(1, 0, 0); step(0, 0, 0);

        // Asynchronous reset mid-edit, next held through release.
        step(1, 0, 0); step(0, 0, 0); step(1, 0, 0); step(0, 0, 0);
        step(0, 1, 0); step(0, 0, 0); step(0, 1, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", 32'(dut_vec()), 32'h0);
        model_reset();
        btn_next = 1'b1;
        @(posedge clk);
        #1 check("reset_hold", 32'(dut_vec()), 32'h0);
        rst_n = 1'b1;
        step(0, 1, 0);
        check("held_next_after_reset", 32'(dut_vec()), 32'h0);
        step(0, 0, 0);

        for (int ph = 0; ph < 3; ph++) begin
            int p;
            p = (ph == 0) ? 30 : ((ph == 1) ? 10 : 3);
            for (int i = 0; i < 1000; i++) step(rnd(p), rnd(p), rnd(p));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
